// File: rtl/s15850_tc_pkg.sv
// Shared types and constants for the s15850 terminal-count sequencer.
package s15850_tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] MODE_HOLD = 4'b0000;
    localparam logic [3:0] MODE_UP   = 4'b0001;
    localparam logic [3:0] MODE_DOWN = 4'b0010;
    localparam logic [3:0] MODE_LOAD = 4'b0100;

    // Wide enough for the largest legal TC_HOLD (15).
    localparam int HOLD_W = 4;

endpackage

// File: rtl/s15850_tc_detect.sv
// Combinational all-ones / all-zeros detector for the count value.
module s15850_tc_detect #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] val_i,
    output logic             all_ones_o,
    output logic             all_zeros_o
);

    assign all_ones_o  = &val_i;
    assign all_zeros_o = ~|val_i;

endmodule

// File: rtl/s15850_tc_seq.sv
// Mode-driven up/down/load counter with IDLE/RUN/DONE sequencing and a stretched terminal-count flag.
// Define S15850_TC_WRAP_EN to wrap and keep running on terminal count; otherwise saturate and go to DONE.
module s15850_tc_seq
    import s15850_tc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TC_HOLD = 1
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [3:0]       mode_i,
    input  logic             start_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o,
    output logic             busy_o
);

    localparam logic [WIDTH-1:0]  ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(TC_HOLD);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              tc_q, tc_d;
    logic              busy_q, busy_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic all_ones, all_zeros;
    logic is_up, is_down, is_load, terminal;

    s15850_tc_detect #(.WIDTH(WIDTH)) u_detect (
        .val_i       (cnt_q),
        .all_ones_o  (all_ones),
        .all_zeros_o (all_zeros)
    );

    // Unlisted mode codes decode to none of these, i.e. HOLD.
    assign is_up    = (mode_i == MODE_UP);
    assign is_down  = (mode_i == MODE_DOWN);
    assign is_load  = (mode_i == MODE_LOAD);
    assign terminal = (state_q == RUN) && ((is_up && all_ones) || (is_down && all_zeros));

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN: begin
`ifdef S15850_TC_WRAP_EN
                state_d = RUN;
`else
                if (terminal) state_d = DONE;
`endif
            end
            DONE: if (ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (is_load) cnt_d = load_val_i;
        end else if (state_q == RUN) begin
            if (is_load) begin
                cnt_d = load_val_i;
            end else if (is_up) begin
`ifdef S15850_TC_WRAP_EN
                cnt_d = cnt_q + ONE;
`else
                if (!all_ones) cnt_d = cnt_q + ONE;
`endif
            end else if (is_down) begin
`ifdef S15850_TC_WRAP_EN
                cnt_d = cnt_q - ONE;
`else
                if (!all_zeros) cnt_d = cnt_q - ONE;
`endif
            end
        end

        // A fresh terminal event reloads the hold counter even mid-pulse.
        hold_d = hold_q;
        if (terminal) begin
            hold_d = HOLD_INIT;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
        tc_d   = (hold_d != '0);
        busy_d = (state_d != IDLE);
    end

    assign cnt_o  = cnt_q;
    assign tc_o   = tc_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_s15850_tc_seq.sv
// Directed, table-driven bench for s15850_tc_seq (WIDTH=8, TC_HOLD=3); follows S15850_TC_WRAP_EN like the RTL.
module tb_s15850_tc_seq;

    localparam logic [3:0] M_HOLD = 4'b0000;
    localparam logic [3:0] M_UP   = 4'b0001;
    localparam logic [3:0] M_DOWN = 4'b0010;
    localparam logic [3:0] M_LOAD = 4'b0100;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] mode;
        logic       start;
        logic       ack;
        logic [7:0] load;
        logic [7:0] exp_cnt;
        logic       exp_tc;
        logic       exp_busy;
    } vec_t;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] mode_i = 4'b0000;
    logic       start_i = 1'b0;
    logic       ack_i = 1'b0;
    logic [7:0] load_val_i = 8'h00;
    logic [7:0] cnt_o;
    logic       tc_o;
    logic       busy_o;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    s15850_tc_seq #(.WIDTH(8), .TC_HOLD(3)) dut (
        .CK         (CK),
        .RST        (RST),
        .mode_i     (mode_i),
        .start_i    (start_i),
        .ack_i      (ack_i),
        .load_val_i (load_val_i),
        .cnt_o      (cnt_o),
        .tc_o       (tc_o),
        .busy_o     (busy_o)
    );

    always #5 CK = ~CK;

    function automatic vec_t mk(string n, logic r, logic [3:0] m, logic s, logic a, logic [7:0] l,
                                logic [7:0] ec, logic et, logic eb);
        vec_t v;
        v.name = n; v.rst = r; v.mode = m; v.start = s; v.ack = a; v.load = l;
        v.exp_cnt = ec; v.exp_tc = et; v.exp_busy = eb;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge CK);
        RST = v.rst; mode_i = v.mode; start_i = v.start; ack_i = v.ack; load_val_i = v.load;
    endtask

    task automatic checkOutput(input vec_t v);
        checks++;
        if (cnt_o !== v.exp_cnt) begin
            errors++;
            $display("[TB] FAIL %s cnt_o: got %h expected %h", v.name, cnt_o, v.exp_cnt);
        end
        checks++;
        if (tc_o !== v.exp_tc) begin
            errors++;
            $display("[TB] FAIL %s tc_o: got %b expected %b", v.name, tc_o, v.exp_tc);
        end
        checks++;
        if (busy_o !== v.exp_busy) begin
            errors++;
            $display("[TB] FAIL %s busy_o: got %b expected %b", v.name, busy_o, v.exp_busy);
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(posedge CK);
        #1;
        checkOutput(v);
    endtask

    initial begin
        // Reset, IDLE behaviour, RUN arithmetic, illegal modes, approach to all-ones.
        vecs.push_back(mk("rst0",        1, M_HOLD,  0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("rst1",        1, M_HOLD,  0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("idle_hold",   0, M_HOLD,  0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("idle_up",     0, M_UP,    0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("idle_down",   0, M_DOWN,  0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk("idle_load",   0, M_LOAD,  0, 0, 8'h10, 8'h10, 0, 0));
        vecs.push_back(mk("idle_ack",    0, M_HOLD,  0, 1, 8'h00, 8'h10, 0, 0));
        vecs.push_back(mk("start",       0, M_HOLD,  1, 0, 8'h00, 8'h10, 0, 1));
        vecs.push_back(mk("run_up",      0, M_UP,    0, 0, 8'h00, 8'h11, 0, 1));
        vecs.push_back(mk("run_up_st",   0, M_UP,    1, 0, 8'h00, 8'h12, 0, 1));
        vecs.push_back(mk("run_down",    0, M_DOWN,  0, 0, 8'h00, 8'h11, 0, 1));
        vecs.push_back(mk("ill_0011",    0, 4'b0011, 0, 0, 8'h77, 8'h11, 0, 1));
        vecs.push_back(mk("ill_0111",    0, 4'b0111, 0, 0, 8'h77, 8'h11, 0, 1));
        vecs.push_back(mk("ill_1000",    0, 4'b1000, 0, 0, 8'h77, 8'h11, 0, 1));
        vecs.push_back(mk("run_load",    0, M_LOAD,  0, 0, 8'h05, 8'h05, 0, 1));
        vecs.push_back(mk("run_ack",     0, M_HOLD,  0, 1, 8'h00, 8'h05, 0, 1));
        vecs.push_back(mk("load_fd",     0, M_LOAD,  0, 0, 8'hFD, 8'hFD, 0, 1));
        vecs.push_back(mk("up_fe",       0, M_UP,    0, 0, 8'h00, 8'hFE, 0, 1));
        vecs.push_back(mk("up_ff",       0, M_UP,    0, 0, 8'h00, 8'hFF, 0, 1));

        for (int i = 0; i < vecs.size(); i++) runVec(vecs[i]);

`ifdef S15850_TC_WRAP_EN
        // Wrap build: terminal UP wraps to 00, stays in RUN, tc_o high 3 cycles.
        runVec(mk("w_term_up",   0, M_UP,   0, 0, 8'h00, 8'h00, 1, 1));
        runVec(mk("w_up_01",     0, M_UP,   0, 0, 8'h00, 8'h01, 1, 1));
        runVec(mk("w_hold1",     0, M_HOLD, 0, 0, 8'h00, 8'h01, 1, 1));
        runVec(mk("w_hold2",     0, M_HOLD, 0, 0, 8'h00, 8'h01, 0, 1));
        runVec(mk("w_ack_start", 0, M_HOLD, 1, 1, 8'h00, 8'h01, 0, 1));
        // DOWN through zero twice, second event restarts the hold count.
        runVec(mk("w_dn_00",     0, M_DOWN, 0, 0, 8'h00, 8'h00, 0, 1));
        runVec(mk("w_dn_term1",  0, M_DOWN, 0, 0, 8'h00, 8'hFF, 1, 1));
        runVec(mk("w_load_00",   0, M_LOAD, 0, 0, 8'h00, 8'h00, 1, 1));
        runVec(mk("w_dn_term2",  0, M_DOWN, 0, 0, 8'h00, 8'hFF, 1, 1));
        runVec(mk("w_ext1",      0, M_HOLD, 0, 0, 8'h00, 8'hFF, 1, 1));
        runVec(mk("w_ext2",      0, M_HOLD, 0, 0, 8'h00, 8'hFF, 1, 1));
        runVec(mk("w_ext_end",   0, M_HOLD, 0, 0, 8'h00, 8'hFF, 0, 1));
        runVec(mk("w_up_term",   0, M_UP,   0, 0, 8'h00, 8'h00, 1, 1));
        runVec(mk("w_rst_tc",    1, M_UP,   1, 1, 8'h55, 8'h00, 0, 0));
        runVec(mk("w_post_rst",  0, M_HOLD, 0, 0, 8'h00, 8'h00, 0, 0));
`else
        // Saturating build: terminal UP holds FF, enters DONE, tc_o high 3 cycles.
        runVec(mk("s_term_up",   0, M_UP,   0, 0, 8'h00, 8'hFF, 1, 1));
        runVec(mk("s_done_up",   0, M_UP,   0, 0, 8'h00, 8'hFF, 1, 1));
        runVec(mk("s_done_load", 0, M_LOAD, 0, 0, 8'h33, 8'hFF, 1, 1));
        runVec(mk("s_tc_end",    0, M_HOLD, 0, 0, 8'h00, 8'hFF, 0, 1));
        runVec(mk("s_ack_start", 0, M_HOLD, 1, 1, 8'h00, 8'hFF, 0, 0));
        runVec(mk("s_start_hld", 0, M_HOLD, 1, 0, 8'h00, 8'hFF, 0, 1));
        runVec(mk("s_term_again",0, M_UP,   0, 0, 8'h00, 8'hFF, 1, 1));
        runVec(mk("s_rst_done",  1, M_UP,   1, 1, 8'h55, 8'h00, 0, 0));
        runVec(mk("s_post_rst",  0, M_HOLD, 0, 0, 8'h00, 8'h00, 0, 0));
        // DOWN from 01 to 00, then terminal: saturate at 00 and enter DONE.
        runVec(mk("s_load_01",   0, M_LOAD, 0, 0, 8'h01, 8'h01, 0, 0));
        runVec(mk("s_start2",    0, M_HOLD, 1, 0, 8'h00, 8'h01, 0, 1));
        runVec(mk("s_dn_00",     0, M_DOWN, 0, 0, 8'h00, 8'h00, 0, 1));
        runVec(mk("s_dn_term",   0, M_DOWN, 0, 0, 8'h00, 8'h00, 1, 1));
        runVec(mk("s_tc2",       0, M_HOLD, 0, 0, 8'h00, 8'h00, 1, 1));
        runVec(mk("s_tc3",       0, M_HOLD, 0, 0, 8'h00, 8'h00, 1, 1));
        runVec(mk("s_tc_off",    0, M_HOLD, 0, 0, 8'h00, 8'h00, 0, 1));
        runVec(mk("s_done_dn",   0, M_DOWN, 0, 0, 8'h00, 8'h00, 0, 1));
        runVec(mk("s_ack",       0, M_HOLD, 0, 1, 8'h00, 8'h00, 0, 0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
